// File: rtl/rf_pkg.sv
// Shared types for the register-file write-port scheduler.
package rf_pkg;

    localparam int REG_W = 5;
    localparam int XLEN  = 32;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } wb_beat_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of writeback beats; pointers carry one extra wrap bit so
// full and empty are told apart by the MSB.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  wb_beat_t                 din_i,
    input  logic                     pop_i,
    output wb_beat_t                 dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    wb_beat_t    mem_q [DEPTH];
    logic [AW:0] wptr_q, rptr_q;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i && !full_o) wptr_q <= wptr_q + PTR_ONE;
            if (pop_i && !empty_o) rptr_q <= rptr_q + PTR_ONE;
        end
    end

    // Storage needs no reset: an empty FIFO never presents its head.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/rf_wb_sched.sv
// Register-file write-port arbiter (ALU > buffered load > direct load) with a
// load busy scoreboard. Define RF_WB_PERF_EN to build the A/B conflict counter.
module rf_wb_sched
    import rf_pkg::*;
#(
    parameter int B_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        A_VALID,
    input  logic [4:0]  A_RD,
    input  logic [31:0] A_DATA,
    input  logic        B_VALID,
    output logic        B_READY,
    input  logic [4:0]  B_RD,
    input  logic [31:0] B_DATA,
    input  logic        ISSUE_VALID,
    input  logic [4:0]  ISSUE_RS1,
    input  logic [4:0]  ISSUE_RS2,
    input  logic [4:0]  ISSUE_RD,
    input  logic        ISSUE_WE,
    input  logic        ISSUE_LONG,
    output logic        STALL,
    output logic [4:0]  WNUM,
    output logic [31:0] WDATA,
    output logic        RegWrite,
    output logic [31:0] CONFLICT_CNT
);

    localparam int CW = $clog2(B_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(B_DEPTH);

    wb_beat_t        fifo_head, beat_d;
    logic            fifo_full, fifo_empty, fifo_push, fifo_pop, b_acc;
    logic [CW-1:0]   fifo_cnt;
    logic            win_vld_d, win_b_d;
    logic [4:0]      wnum_q;
    logic [31:0]     wdata_q;
    logic            we_q, src_b_q;
    logic [31:1]     busy_q, busy_d;
    logic [31:0]     busy_w;
    logic            set_en;

    // Ready depends only on the registered occupancy, never on this cycle's requests.
    assign B_READY   = (fifo_cnt < DEPTH_C);
    assign b_acc     = B_VALID && B_READY;
    assign fifo_pop  = !A_VALID && !fifo_empty;
    assign fifo_push = b_acc && !fifo_full && (A_VALID || !fifo_empty);

    rf_wb_fifo #(.DEPTH(B_DEPTH)) u_bfifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .push_i  (fifo_push),
        .din_i   ('{rd: B_RD, data: B_DATA}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_comb begin
        win_vld_d = 1'b0;
        win_b_d   = 1'b0;
        beat_d    = '0;
        if (A_VALID) begin
            win_vld_d = 1'b1;
            beat_d    = '{rd: A_RD, data: A_DATA};
        end else if (!fifo_empty) begin
            win_vld_d = 1'b1;
            win_b_d   = 1'b1;
            beat_d    = fifo_head;
        end else if (B_VALID) begin
            win_vld_d = 1'b1;
            win_b_d   = 1'b1;
            beat_d    = '{rd: B_RD, data: B_DATA};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wnum_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            src_b_q <= 1'b0;
        end else begin
            we_q    <= win_vld_d && (beat_d.rd != '0);
            src_b_q <= win_vld_d && win_b_d;
            if (win_vld_d) begin
                wnum_q  <= beat_d.rd;
                wdata_q <= beat_d.data;
            end
        end
    end

    assign WNUM     = wnum_q;
    assign WDATA    = wdata_q;
    assign RegWrite = we_q;

    assign busy_w = {busy_q, 1'b0};
    assign STALL  = ISSUE_VALID && (busy_w[ISSUE_RS1] || busy_w[ISSUE_RS2] ||
                                    (ISSUE_WE && busy_w[ISSUE_RD]));
    assign set_en = ISSUE_VALID && !STALL && ISSUE_LONG && ISSUE_WE && (ISSUE_RD != '0);

    // Clear on a committed load write, then set so a same-edge set wins.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < 32; r++) begin
            if (we_q && src_b_q && (wnum_q == r[4:0])) busy_d[r] = 1'b0;
            if (set_en && (ISSUE_RD == r[4:0]))         busy_d[r] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) busy_q <= '0;
        else        busy_q <= busy_d;
    end

`ifdef RF_WB_PERF_EN
    logic [31:0] conflict_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                                  conflict_q <= '0;
        else if (A_VALID && (!fifo_empty || b_acc))  conflict_q <= conflict_q + 32'd1;
    end

    assign CONFLICT_CNT = conflict_q;
`else
    assign CONFLICT_CNT = '0;
`endif

endmodule

// File: tb/tb_rf_wb_sched.sv
// Scoreboard bench for rf_wb_sched: expected writes are queued as stimulus is
// driven and popped by a monitor whenever RegWrite is observed.
module tb_rf_wb_sched;
    import rf_pkg::*;

    logic        CLK, RST_N;
    logic        A_VALID, B_VALID, B_READY;
    logic [4:0]  A_RD, B_RD, ISSUE_RS1, ISSUE_RS2, ISSUE_RD, WNUM;
    logic [31:0] A_DATA, B_DATA, WDATA, CONFLICT_CNT;
    logic        ISSUE_VALID, ISSUE_WE, ISSUE_LONG, STALL, RegWrite;

    int       n_cmp = 0;
    int       n_err = 0;
    wb_beat_t sb_q[$];
    wb_beat_t exp_b;
    logic [31:0] exp_cnt;

    rf_wb_sched #(.B_DEPTH(2)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .A_VALID(A_VALID), .A_RD(A_RD), .A_DATA(A_DATA),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_RD(B_RD), .B_DATA(B_DATA),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_RS1(ISSUE_RS1), .ISSUE_RS2(ISSUE_RS2),
        .ISSUE_RD(ISSUE_RD), .ISSUE_WE(ISSUE_WE), .ISSUE_LONG(ISSUE_LONG),
        .STALL(STALL), .WNUM(WNUM), .WDATA(WDATA), .RegWrite(RegWrite),
        .CONFLICT_CNT(CONFLICT_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Every observed write must match the oldest outstanding expectation.
    always @(posedge CLK) begin
        #1;
        if (RST_N === 1'b1 && RegWrite === 1'b1) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h, required no write", WNUM, WDATA);
            end else begin
                exp_b = sb_q.pop_front();
                if (WNUM !== exp_b.rd || WDATA !== exp_b.data) begin
                    n_err++;
                    $display("FAIL wb_order: got rd=%0d data=%h, required rd=%0d data=%h",
                             WNUM, WDATA, exp_b.rd, exp_b.data);
                end
            end
        end
    end

    task automatic idle_inputs();
        A_VALID = 0; A_RD = 0; A_DATA = 0;
        B_VALID = 0; B_RD = 0; B_DATA = 0;
        ISSUE_VALID = 0; ISSUE_RS1 = 0; ISSUE_RS2 = 0; ISSUE_RD = 0;
        ISSUE_WE = 0; ISSUE_LONG = 0;
    endtask

    // Leaves the bench 2 time units after a rising edge with reset released.
    task automatic do_reset();
        idle_inputs();
        RST_N = 0;
        sb_q.delete();
        @(posedge CLK); #2;
        RST_N = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST_N = 0;
        ISSUE_VALID = 1; ISSUE_RS1 = 5; ISSUE_RS2 = 6; ISSUE_RD = 7; ISSUE_WE = 1;
        #2;
        n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite: got %b, required 0", RegWrite); end
        n_cmp++; if (WNUM !== 5'd0) begin n_err++; $display("FAIL reset_wnum: got %0d, required 0", WNUM); end
        n_cmp++; if (WDATA !== 32'd0) begin n_err++; $display("FAIL reset_wdata: got %h, required 0", WDATA); end
        n_cmp++; if (B_READY !== 1'b1) begin n_err++; $display("FAIL reset_bready: got %b, required 1", B_READY); end
        n_cmp++; if (STALL !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b, required 0", STALL); end
        n_cmp++; if (CONFLICT_CNT !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %0d, required 0", CONFLICT_CNT); end
        @(posedge CLK); #2;
        idle_inputs();
        RST_N = 1;
    endtask

    task automatic test_a_write();
        do_reset();
        A_VALID = 1; A_RD = 5; A_DATA = 32'h11;
        sb_q.push_back('{rd: 5'd5, data: 32'h11});
        #1;
        n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL a_early: got RegWrite=%b, required 0", RegWrite); end
        @(posedge CLK); #1;
        A_VALID = 0; #1;
        n_cmp++; if (RegWrite !== 1'b1 || WNUM !== 5'd5 || WDATA !== 32'h11) begin
            n_err++; $display("FAIL a_latency: got we=%b rd=%0d data=%h, required we=1 rd=5 data=11", RegWrite, WNUM, WDATA);
        end
        @(posedge CLK); #2;
        n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL a_idle: got RegWrite=%b, required 0", RegWrite); end
        n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL a_drain: got %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_conflict();
        logic exp_rdy [3];
        exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b0; exp_rdy[2] = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            A_VALID = 1; A_RD = 5'(i + 1); A_DATA = 32'hA0 + 32'(i);
            B_VALID = 1; B_RD = 7; B_DATA = 32'h70 + 32'(i);
            sb_q.push_back('{rd: 5'(i + 1), data: 32'hA0 + 32'(i)});
            @(posedge CLK); #2;
            n_cmp++; if (B_READY !== exp_rdy[i]) begin
                n_err++; $display("FAIL conflict_bready%0d: got %b, required %b", i, B_READY, exp_rdy[i]);
            end
        end
        sb_q.push_back('{rd: 5'd7, data: 32'h70});
        sb_q.push_back('{rd: 5'd7, data: 32'h71});
        idle_inputs();
`ifdef RF_WB_PERF_EN
        exp_cnt = 32'd3;
`else
        exp_cnt = 32'd0;
`endif
        n_cmp++; if (CONFLICT_CNT !== exp_cnt) begin n_err++; $display("FAIL conflict_cnt: got %0d, required %0d", CONFLICT_CNT, exp_cnt); end
        @(posedge CLK); #2;
        n_cmp++; if (B_READY !== 1'b1) begin n_err++; $display("FAIL conflict_bready_free: got %b, required 1", B_READY); end
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin @(posedge CLK); #2; end
        n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL conflict_drain: got %0d pending, required 0", sb_q.size()); end
        n_cmp++; if (CONFLICT_CNT !== exp_cnt) begin n_err++; $display("FAIL conflict_cnt_hold: got %0d, required %0d", CONFLICT_CNT, exp_cnt); end
    endtask

    task automatic test_raw_stall();
        do_reset();
        ISSUE_VALID = 1; ISSUE_RD = 9; ISSUE_WE = 1; ISSUE_LONG = 1; #1;
        n_cmp++; if (STALL !== 1'b0) begin n_err++; $display("FAIL raw_load_issue: got STALL=%b, required 0", STALL); end
        @(posedge CLK); #1;
        ISSUE_RS1 = 9; ISSUE_RD = 10; ISSUE_LONG = 0; #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (STALL !== 1'b1) begin n_err++; $display("FAIL raw_hold%0d: got STALL=%b, required 1", i, STALL); end
            @(posedge CLK); #2;
        end
        B_VALID = 1; B_RD = 9; B_DATA = 32'h99;
        sb_q.push_back('{rd: 5'd9, data: 32'h99});
        @(posedge CLK); #1;
        B_VALID = 0; #1;
        n_cmp++; if (RegWrite !== 1'b1 || WNUM !== 5'd9) begin
            n_err++; $display("FAIL raw_b_latency: got we=%b rd=%0d, required we=1 rd=9", RegWrite, WNUM);
        end
        n_cmp++; if (STALL !== 1'b1) begin n_err++; $display("FAIL raw_during_write: got STALL=%b, required 1", STALL); end
        @(posedge CLK); #2;
        n_cmp++; if (STALL !== 1'b0) begin n_err++; $display("FAIL raw_release: got STALL=%b, required 0", STALL); end
        ISSUE_VALID = 0;
        n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL raw_drain: got %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_waw();
        do_reset();
        ISSUE_VALID = 1; ISSUE_RD = 3; ISSUE_WE = 1; ISSUE_LONG = 1;
        @(posedge CLK); #1;
        ISSUE_RS1 = 1; ISSUE_RS2 = 2; ISSUE_RD = 3; ISSUE_WE = 1; ISSUE_LONG = 0; #1;
        n_cmp++; if (STALL !== 1'b1) begin n_err++; $display("FAIL waw_stall: got STALL=%b, required 1", STALL); end
        ISSUE_WE = 0; #1;
        n_cmp++; if (STALL !== 1'b0) begin n_err++; $display("FAIL waw_no_we: got STALL=%b, required 0", STALL); end
        ISSUE_RS2 = 3; #1;
        n_cmp++; if (STALL !== 1'b1) begin n_err++; $display("FAIL waw_rs2: got STALL=%b, required 1", STALL); end
        ISSUE_VALID = 0; #1;
        n_cmp++; if (STALL !== 1'b0) begin n_err++; $display("FAIL waw_novalid: got STALL=%b, required 0", STALL); end
    endtask

    task automatic test_x0();
        do_reset();
        A_VALID = 1; A_RD = 0; A_DATA = 32'h55;
        @(posedge CLK); #1;
        A_VALID = 0; #1;
        n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL x0_a_write: got RegWrite=%b, required 0", RegWrite); end
        B_VALID = 1; B_RD = 0; B_DATA = 32'h66;
        @(posedge CLK); #1;
        B_VALID = 0; #1;
        n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL x0_b_write: got RegWrite=%b, required 0", RegWrite); end
        ISSUE_VALID = 1; ISSUE_RD = 0; ISSUE_WE = 1; ISSUE_LONG = 1;
        @(posedge CLK); #1;
        ISSUE_RS1 = 0; ISSUE_LONG = 0; #1;
        n_cmp++; if (STALL !== 1'b0) begin n_err++; $display("FAIL x0_stall: got STALL=%b, required 0", STALL); end
        ISSUE_VALID = 0;
        @(posedge CLK); #2;
        n_cmp++; if (B_READY !== 1'b1) begin n_err++; $display("FAIL x0_consumed: got B_READY=%b, required 1", B_READY); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            A_VALID = 1; A_RD = 5'(20 + i); A_DATA = 32'hC100 + 32'(i);
            sb_q.push_back('{rd: 5'(20 + i), data: 32'hC100 + 32'(i)});
            B_VALID = (i == 1);
            B_RD = 24; B_DATA = 32'hB0;
            @(posedge CLK); #2;
        end
        sb_q.push_back('{rd: 5'd24, data: 32'hB0});
        idle_inputs();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin @(posedge CLK); #2; end
        n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL b2b_drain: got %0d pending, required 0", sb_q.size()); end
        @(posedge CLK); #2;
        B_VALID = 1; B_RD = 12; B_DATA = 32'hC0;
        sb_q.push_back('{rd: 5'd12, data: 32'hC0});
        @(posedge CLK); #1;
        B_VALID = 0; #1;
        n_cmp++; if (RegWrite !== 1'b1 || WNUM !== 5'd12 || WDATA !== 32'hC0) begin
            n_err++; $display("FAIL b_direct: got we=%b rd=%0d data=%h, required we=1 rd=12 data=c0", RegWrite, WNUM, WDATA);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ISSUE_VALID = 1; ISSUE_RD = 4; ISSUE_WE = 1; ISSUE_LONG = 1;
        @(posedge CLK); #2;
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            A_VALID = 1; A_RD = 5'(1 + i); A_DATA = 32'hD0 + 32'(i);
            B_VALID = 1; B_RD = 4; B_DATA = 32'h40 + 32'(i);
            sb_q.push_back('{rd: 5'(1 + i), data: 32'hD0 + 32'(i)});
            @(posedge CLK); #2;
        end
        idle_inputs();
        ISSUE_VALID = 1; ISSUE_RS1 = 4; #1;
        n_cmp++; if (B_READY !== 1'b0 || STALL !== 1'b1) begin
            n_err++; $display("FAIL rmid_setup: got B_READY=%b STALL=%b, required 0 1", B_READY, STALL);
        end
        RST_N = 0; #1;
        n_cmp++; if (RegWrite !== 1'b0 || WNUM !== 5'd0 || WDATA !== 32'd0) begin
            n_err++; $display("FAIL rmid_outputs: got we=%b rd=%0d data=%h, required 0 0 0", RegWrite, WNUM, WDATA);
        end
        n_cmp++; if (B_READY !== 1'b1) begin n_err++; $display("FAIL rmid_bready: got %b, required 1", B_READY); end
        n_cmp++; if (STALL !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got STALL=%b, required 0", STALL); end
        n_cmp++; if (CONFLICT_CNT !== 32'd0) begin n_err++; $display("FAIL rmid_cnt: got %0d, required 0", CONFLICT_CNT); end
        n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL rmid_drain: got %0d pending, required 0", sb_q.size()); end
        ISSUE_VALID = 0;
        @(posedge CLK); #2;
        RST_N = 1;
        // Discarded FIFO entries must never reach the write port.
        repeat (4) begin @(posedge CLK); #2; end
    endtask

    initial begin
        test_reset();
        test_a_write();
        test_conflict();
        test_raw_stall();
        test_waw();
        test_x0();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
